// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package regfile_pkg;

   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] R31 = 5'd31;
   localparam logic [REG_AW-1:0] XP  = 5'd30;
   localparam logic [REG_AW-1:0] SP  = 5'd29;
   localparam logic [REG_AW-1:0] LP  = 5'd28;
   localparam logic [REG_AW-1:0] BP  = 5'd27;

   typedef enum logic {
      NORMAL,
      DRAIN
   } arb_state_t;

   typedef enum logic [1:0] {
      G_NONE,
      G_SKID,
      G_MEM,
      G_ALU
   } grant_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for outstanding loads. r31 is hard-wired not busy.
import regfile_pkg::*;

module rf_scoreboard (
   input  logic              clock,
   input  logic              reset,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] look_ra,
   input  logic [REG_AW-1:0] look_rb,
   input  logic [REG_AW-1:0] look_rd,
   output logic              busy_ra,
   output logic              busy_rb,
   output logic              busy_rd
);

   logic [30:0] busy_q;
   logic [31:0] busy_ext;

   // Clear is applied before set so a clear and a set in one cycle both land.
   always_ff @(posedge clock) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         if (clr_en && clr_addr != R31) busy_q[clr_addr] <= 1'b0;
         if (set_en && set_addr != R31) busy_q[set_addr] <= 1'b1;
      end
   end

   // Lookups see only the registered vector; no same-cycle clear bypass.
   always_comb begin
      busy_ext = {1'b0, busy_q};
      busy_ra  = busy_ext[look_ra];
      busy_rb  = busy_ext[look_rb];
      busy_rd  = busy_ext[look_rd];
   end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter (skid / forced mem / ALU / mem) with
// load-use interlock.
//
// state  | meaning
// NORMAL | skid empty, normal priority arbitration
// DRAIN  | skid full, alu_stall high, skid entry written this cycle
import regfile_pkg::*;

module regfile_wb_scheduler #(
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] issue_ra,
   input  logic [REG_AW-1:0] issue_rb,
   input  logic [REG_AW-1:0] issue_rd,
   input  logic              issue_we,
   input  logic              issue_long,
   output logic              issue_stall,
   input  logic              alu_wb_valid,
   input  logic [REG_AW-1:0] alu_wb_addr,
   input  logic [DW-1:0]     alu_wb_data,
   output logic              alu_stall,
   input  logic              mem_wb_valid,
   input  logic [REG_AW-1:0] mem_wb_addr,
   input  logic [DW-1:0]     mem_wb_data,
   output logic              mem_wb_ready,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_wa,
   output logic [DW-1:0]     rf_wdata
);

   localparam int SCW = 4;

   arb_state_t        state_q, state_d;
   grant_t            grant;
   logic              capture_skid;
   logic [SCW-1:0]    starve_cnt;
   logic              starve_max;
   logic [REG_AW-1:0] skid_addr;
   logic [DW-1:0]     skid_data;
   logic [REG_AW-1:0] wb_addr;
   logic [DW-1:0]     wb_data;
   logic              rf_from_mem;
   logic              busy_ra, busy_rb, busy_rd;

   assign starve_max   = (starve_cnt == SCW'(STARVE_LIMIT));
   assign alu_stall    = (state_q == DRAIN);
   assign mem_wb_ready = (grant == G_MEM);
   assign issue_stall  = issue_valid & (busy_ra | busy_rb | (issue_we & busy_rd));

   rf_scoreboard u_sb (
      .clock    (clock),
      .reset    (reset),
      .set_en   (issue_valid & ~issue_stall & issue_we & issue_long),
      .set_addr (issue_rd),
      .clr_en   (rf_we & rf_from_mem),
      .clr_addr (rf_wa),
      .look_ra  (issue_ra),
      .look_rb  (issue_rb),
      .look_rd  (issue_rd),
      .busy_ra  (busy_ra),
      .busy_rb  (busy_rb),
      .busy_rd  (busy_rd)
   );

   // Arbiter state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= NORMAL;
      else       state_q <= state_d;
   end

   // Grant selection and next state; nothing is granted while in reset.
   always_comb begin
      grant        = G_NONE;
      state_d      = state_q;
      capture_skid = 1'b0;
      if (!reset) begin
         unique case (state_q)
            DRAIN: begin
               grant   = G_SKID;
               state_d = NORMAL;
            end
            default: begin
               if (mem_wb_valid && starve_max) begin
                  grant = G_MEM;
                  if (alu_wb_valid) begin
                     capture_skid = 1'b1;
                     state_d      = DRAIN;
                  end
               end else if (alu_wb_valid) begin
                  grant = G_ALU;
               end else if (mem_wb_valid) begin
                  grant = G_MEM;
               end
            end
         endcase
      end
   end

   // Write-port source mux.
   always_comb begin
      wb_addr = '0;
      wb_data = '0;
      unique case (grant)
         G_SKID:  begin wb_addr = skid_addr;   wb_data = skid_data;   end
         G_MEM:   begin wb_addr = mem_wb_addr; wb_data = mem_wb_data; end
         G_ALU:   begin wb_addr = alu_wb_addr; wb_data = alu_wb_data; end
         default: begin wb_addr = '0;          wb_data = '0;          end
      endcase
   end

   // Skid buffer holds the ALU request that collided with a forced mem grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         skid_addr <= '0;
         skid_data <= '0;
      end else if (capture_skid) begin
         skid_addr <= alu_wb_addr;
         skid_data <= alu_wb_data;
      end
   end

   // Memory starvation counter, saturating at the force-grant threshold.
   always_ff @(posedge clock) begin
      if (reset)                             starve_cnt <= '0;
      else if (!mem_wb_valid || mem_wb_ready) starve_cnt <= '0;
      else if (!starve_max)                  starve_cnt <= starve_cnt + 1'b1;
   end

   // Registered write port; r31 writes are consumed but never enabled.
   always_ff @(posedge clock) begin
      if (reset) begin
         rf_we       <= 1'b0;
         rf_wa       <= '0;
         rf_wdata    <= '0;
         rf_from_mem <= 1'b0;
      end else begin
         rf_we       <= (grant != G_NONE) && (wb_addr != R31);
         rf_from_mem <= (grant == G_MEM);
         if (grant != G_NONE) begin
            rf_wa    <= wb_addr;
            rf_wdata <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler; writes are checked in order
// against a queue of expected {addr,data} pairs.
module tb_regfile_wb_scheduler;

   logic        clock, reset;
   logic        issue_valid, issue_we, issue_long, issue_stall;
   logic [4:0]  issue_ra, issue_rb, issue_rd;
   logic        alu_wb_valid, alu_stall;
   logic [4:0]  alu_wb_addr;
   logic [31:0] alu_wb_data;
   logic        mem_wb_valid, mem_wb_ready;
   logic [4:0]  mem_wb_addr;
   logic [31:0] mem_wb_data;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wdata;

   int          n_chk = 0;
   int          n_err = 0;
   logic [36:0] exp_q[$];

   regfile_wb_scheduler #(.DW(32), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ra(issue_ra), .issue_rb(issue_rb),
      .issue_rd(issue_rd), .issue_we(issue_we), .issue_long(issue_long),
      .issue_stall(issue_stall),
      .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
      .alu_wb_data(alu_wb_data), .alu_stall(alu_stall),
      .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr),
      .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk_val(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      issue_valid  = 1'b0; issue_ra = '0; issue_rb = '0; issue_rd = '0;
      issue_we     = 1'b0; issue_long = 1'b0;
      alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
      mem_wb_valid = 1'b0; mem_wb_addr = '0; mem_wb_data = '0;
   endtask

   task automatic issue(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                        input logic we, input logic lg);
      issue_valid = 1'b1; issue_ra = ra; issue_rb = rb; issue_rd = rd;
      issue_we = we; issue_long = lg;
   endtask

   task automatic alu(input logic [4:0] a, input logic [31:0] d);
      alu_wb_valid = 1'b1; alu_wb_addr = a; alu_wb_data = d;
   endtask

   task automatic mem(input logic [4:0] a, input logic [31:0] d);
      mem_wb_valid = 1'b1; mem_wb_addr = a; mem_wb_data = d;
   endtask

   // Write-port monitor and ALU handshake protocol check.
   always @(negedge clock) begin
      logic [36:0] e;
      if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk_val("wb_extra", 64'({rf_wa, rf_wdata}), 64'h0);
         end else begin
            e = exp_q.pop_front();
            chk_val("wb", 64'({rf_wa, rf_wdata}), 64'(e));
         end
      end
      if (alu_stall === 1'b1) chk_val("alu_protocol", 64'(alu_wb_valid), 64'h0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every input active.
      idle();
      reset = 1'b1;
      issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
      alu(5'd4, 32'h1);
      mem(5'd5, 32'h2);
      tick(); tick();
      chk_val("rst_rf_we",    64'(rf_we), 64'h0);
      chk_val("rst_rf_wa",    64'(rf_wa), 64'h0);
      chk_val("rst_rf_wdata", 64'(rf_wdata), 64'h0);
      chk_val("rst_alu_stall",64'(alu_stall), 64'h0);
      chk_val("rst_mem_ready",64'(mem_wb_ready), 64'h0);
      chk_val("rst_issue_stall", 64'(issue_stall), 64'h0);
      idle();
      reset = 1'b0;
      tick();
      chk_val("post_rst_rf_we", 64'(rf_we), 64'h0);

      // Load-use interlock on r5.
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      #1 chk_val("ld5_issue", 64'(issue_stall), 64'h0);
      tick();
      issue(5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
      #1 chk_val("use5_stall_a", 64'(issue_stall), 64'h1);
      tick();
      mem(5'd5, 32'h5555_0005);
      exp_q.push_back({5'd5, 32'h5555_0005});
      #1 chk_val("ld5_mem_ready", 64'(mem_wb_ready), 64'h1);
      chk_val("use5_stall_b", 64'(issue_stall), 64'h1);
      tick();
      mem_wb_valid = 1'b0;
      #1 chk_val("use5_stall_wb", 64'(issue_stall), 64'h1);
      chk_val("ld5_rf_we", 64'(rf_we), 64'h1);
      tick();
      chk_val("use5_release", 64'(issue_stall), 64'h0);
      tick();
      issue(5'd0, 5'd0, 5'd31, 1'b1, 1'b1);
      #1 chk_val("ld31_issue", 64'(issue_stall), 64'h0);
      tick();
      issue(5'd31, 5'd31, 5'd31, 1'b1, 1'b0);
      #1 chk_val("use31_no_stall", 64'(issue_stall), 64'h0);
      tick();
      idle();

      // Starvation: memory force-granted on the 5th cycle, ALU goes to skid.
      for (int i = 0; i < 5; i++) begin
         alu(5'(10 + i), 32'hA000 + 32'(i));
         mem(5'd12, 32'hBEEF);
         #1 chk_val("starve_mem_ready", 64'(mem_wb_ready), (i == 4) ? 64'h1 : 64'h0);
         chk_val("starve_alu_stall", 64'(alu_stall), 64'h0);
         if (i < 4) begin
            exp_q.push_back({5'(10 + i), 32'hA000 + 32'(i)});
         end else begin
            exp_q.push_back({5'd12, 32'hBEEF});
            exp_q.push_back({5'd14, 32'hA004});
         end
         tick();
      end
      alu_wb_valid = 1'b0;
      mem(5'd13, 32'hC0DE);
      #1 chk_val("drain_alu_stall", 64'(alu_stall), 64'h1);
      chk_val("drain_mem_wait", 64'(mem_wb_ready), 64'h0);
      tick();
      alu(5'd16, 32'hA005);
      exp_q.push_back({5'd16, 32'hA005});
      #1 chk_val("post_drain_stall", 64'(alu_stall), 64'h0);
      chk_val("post_drain_mem", 64'(mem_wb_ready), 64'h0);
      tick();
      alu_wb_valid = 1'b0;
      exp_q.push_back({5'd13, 32'hC0DE});
      #1 chk_val("mem2_ready", 64'(mem_wb_ready), 64'h1);
      tick();
      idle();
      tick(); tick();

      // r31 writes consumed without enabling the register file.
      alu(5'd31, 32'hDEADBEEF);
      #1 chk_val("r31_alu_stall", 64'(alu_stall), 64'h0);
      tick();
      alu(5'd3, 32'h33);
      exp_q.push_back({5'd3, 32'h33});
      #1 chk_val("r31_rf_we", 64'(rf_we), 64'h0);
      chk_val("r31_no_stall", 64'(alu_stall), 64'h0);
      tick();
      idle();
      tick();

      // Simultaneous clear of r7 and set of r9.
      issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
      tick();
      idle();
      mem(5'd7, 32'h77);
      exp_q.push_back({5'd7, 32'h77});
      tick();
      mem_wb_valid = 1'b0;
      issue(5'd0, 5'd0, 5'd9, 1'b1, 1'b1);
      #1 chk_val("ld9_issue", 64'(issue_stall), 64'h0);
      tick();
      issue(5'd7, 5'd0, 5'd1, 1'b1, 1'b0);
      #1 chk_val("use7_cleared", 64'(issue_stall), 64'h0);
      issue(5'd9, 5'd0, 5'd1, 1'b1, 1'b0);
      #1 chk_val("use9_stall", 64'(issue_stall), 64'h1);
      tick();
      idle();

      // Reset while in DRAIN with r3 busy.
      issue(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
      tick();
      idle();
      for (int i = 0; i < 5; i++) begin
         alu(5'(20 + i), 32'hD000 + 32'(i));
         mem(5'd14, 32'hE0);
         #1 chk_val("mf_mem_ready", 64'(mem_wb_ready), (i == 4) ? 64'h1 : 64'h0);
         if (i < 4) exp_q.push_back({5'(20 + i), 32'hD000 + 32'(i)});
         else       exp_q.push_back({5'd14, 32'hE0});
         tick();
      end
      idle();
      #1 chk_val("mf_drain", 64'(alu_stall), 64'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      issue(5'd3, 5'd9, 5'd1, 1'b1, 1'b0);
      #1 chk_val("mf_alu_stall", 64'(alu_stall), 64'h0);
      chk_val("mf_busy_clear", 64'(issue_stall), 64'h0);
      chk_val("mf_rf_we_rst", 64'(rf_we), 64'h0);
      tick();
      idle();
      #1 chk_val("mf_skid_lost", 64'(rf_we), 64'h0);
      tick(); tick();

      chk_val("wb_queue_drained", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
